relu_maxpool: RTL and testbench

//  Downstream stage of the channel accumulator. Consumes the saturated int8 conv

---
 rtl/relu_maxpool_if.sv | 28 ++
 rtl/relu_maxpool.sv | 104 ++++++++++
 tb/tb_relu_maxpool.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/relu_maxpool_if.sv
// Conv result stream in, pooled stream out, plus frame geometry and status.
// Pure wiring; adds no latency.
// No backpressure signals: the producer may present a beat every cycle.
interface relu_maxpool_if #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 5
);
  logic [DIM_W-1:0]  ofmap_w_i;
  logic [DIM_W-1:0]  ofmap_h_i;
  logic              conv_valid_i;
  logic [DATA_W-1:0] conv_result_i;
  logic              pool_valid_o;
  logic [DATA_W-1:0] pool_result_o;
  logic              frame_done_o;
  logic              busy_o;

  // Upstream side: drives geometry and pixels, observes pooled results.
  modport master (
    output ofmap_w_i, ofmap_h_i, conv_valid_i, conv_result_i,
    input  pool_valid_o, pool_result_o, frame_done_o, busy_o
  );

  // Pooling stage side.
  modport slave (
    input  ofmap_w_i, ofmap_h_i, conv_valid_i, conv_result_i,
    output pool_valid_o, pool_result_o, frame_done_o, busy_o
  );
endinterface

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster ofmap, half-width line buffer.
// Latency: pooled value valid 1 cycle after the beat at odd row / odd column.
// No backpressure: every valid input beat is consumed in the cycle it arrives.
module relu_maxpool #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 32,
  parameter int DIM_W  = 5
) (
  input logic           clk,
  input logic           rst_n,
  relu_maxpool_if.slave bus
);
  localparam int LB_D  = MAX_W / 2;
  localparam int LB_AW = DIM_W - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [DIM_W-1:0]  cfg_w, cfg_h;
  logic [DIM_W-1:0]  col, row, col_nxt, row_nxt;
  logic [DIM_W-1:0]  w_eff, h_eff;
  logic [DATA_W-1:0] h_reg;
  logic [DATA_W-1:0] relu_v, hmax, lb_rd, pool_max;
  logic [LB_AW-1:0]  lb_idx;
  logic              beat, last_beat;
  logic              pool_vld_q, frame_done_q;
  logic [DATA_W-1:0] pool_dat_q;

  // Holds the horizontal max of each even-row pair, indexed by pooled column.
  logic [DATA_W-1:0] linebuf [LB_D];

  assign lb_idx = col[DIM_W-1:1];
  assign lb_rd  = linebuf[lb_idx];

  // Next-state, counter advance and the ReLU/compare datapath.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    beat      = bus.conv_valid_i;
    // The first beat of a frame uses the live geometry; it is latched on that same edge.
    w_eff     = (state == IDLE) ? bus.ofmap_w_i : cfg_w;
    h_eff     = (state == IDLE) ? bus.ofmap_h_i : cfg_h;
    last_beat = beat && (col == w_eff) && (row == h_eff);
    relu_v    = bus.conv_result_i[DATA_W-1] ? '0 : bus.conv_result_i;
    // Both operands are non-negative after ReLU, so an unsigned compare is exact.
    hmax      = (h_reg > relu_v) ? h_reg : relu_v;
    pool_max  = (lb_rd > hmax) ? lb_rd : hmax;

    if (beat) begin
      if (col == w_eff) begin
        col_nxt = '0;
        row_nxt = (row == h_eff) ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end

    case (state)
      IDLE:    if (beat) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, geometry latch, position counters, even-column hold and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cfg_w        <= '0;
      cfg_h        <= '0;
      col          <= '0;
      row          <= '0;
      h_reg        <= '0;
      pool_vld_q   <= 1'b0;
      pool_dat_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      pool_vld_q   <= beat && row[0] && col[0];
      frame_done_q <= last_beat;
      if (state == IDLE && beat) begin
        cfg_w <= bus.ofmap_w_i;
        cfg_h <= bus.ofmap_h_i;
      end
      if (beat) begin
        col <= col_nxt;
        row <= row_nxt;
        if (!col[0]) h_reg <= relu_v;
        if (row[0] && col[0]) pool_dat_q <= pool_max;
      end
    end
  end

  // Line buffer write on even-row pair completion; no reset since it is written before read.
  always_ff @(posedge clk) begin
    if (beat && !row[0] && col[0]) linebuf[lb_idx] <= hmax;
  end

  assign bus.pool_valid_o  = pool_vld_q;
  assign bus.pool_result_o = pool_dat_q;
  assign bus.frame_done_o  = frame_done_q;
  assign bus.busy_o        = (state == RUN);
endmodule

// File: tb/tb_relu_maxpool.sv
// Directed table-driven checks plus a randomized 32x32 frame against a window-max model.
// Outputs are compared one cycle after each driven beat.
// The bench drives a beat or an idle cycle every clock; the design never stalls it.
module tb_relu_maxpool;
  logic clk;
  logic rst_n;

  relu_maxpool_if #(.DATA_W(8), .DIM_W(5)) bus ();

  relu_maxpool #(.DATA_W(8), .MAX_W(32), .DIM_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] w;
    logic [4:0] h;
    logic [7:0] dat;
    logic       ev;
    logic [7:0] edat;
    logic       edone;
    logic       ebusy;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_exp = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [4:0] w, input logic [4:0] h,
                     input logic [7:0] dat, input logic ev, input logic [7:0] edat,
                     input logic edone, input logic ebusy);
    vec_t v;
    v.vld = vld; v.w = w; v.h = h; v.dat = dat;
    v.ev = ev; v.edat = edat; v.edone = edone; v.ebusy = ebusy;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs (called right after a falling edge), return after the next falling edge.
  task automatic step(input logic vld, input logic [4:0] w, input logic [4:0] h, input logic [7:0] dat);
    bus.conv_valid_i  = vld;
    bus.ofmap_w_i     = w;
    bus.ofmap_h_i     = h;
    bus.conv_result_i = dat;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_rows(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].vld, tbl[i].w, tbl[i].h, tbl[i].dat);
      if (tbl[i].ev) last_exp = tbl[i].edat;
      chk($sformatf("%s row%0d pool_valid", tag, i), 32'(bus.pool_valid_o), 32'(tbl[i].ev));
      chk($sformatf("%s row%0d pool_result", tag, i), 32'(bus.pool_result_o), 32'(last_exp));
      chk($sformatf("%s row%0d frame_done", tag, i), 32'(bus.frame_done_o), 32'(tbl[i].edone));
      chk($sformatf("%s row%0d busy", tag, i), 32'(bus.busy_o), 32'(tbl[i].ebusy));
    end
  endtask

  function automatic logic [7:0] relu8(input logic [7:0] x);
    return x[7] ? 8'd0 : x;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [7:0] pix  [32][32];
  logic [7:0] expv [16][16];
  logic [7:0] d2x2 [4];

  initial begin
    int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi;
    int idx, cycles, obs;
    logic v;
    int r, c;

    // Test 1: 4x4 ramp 0..15, no gaps, then one idle cycle.
    a_lo = tbl.size();
    for (int i = 0; i < 16; i++)
      add(1'b1, 5'd3, 5'd3, 8'(i), (i == 5 || i == 7 || i == 13 || i == 15),
          8'(i), (i == 15), (i != 15));
    a_hi = tbl.size() - 1;
    add(1'b0, 5'd3, 5'd3, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Test 2: 4x4 all -1 with idle gaps mid-frame; then test 3: 2x2 {127,-128,-128,-128}.
    b_lo = tbl.size();
    for (int i = 0; i < 16; i++) begin
      add(1'b1, 5'd3, 5'd3, 8'hFF, (i == 5 || i == 7 || i == 13 || i == 15),
          8'd0, (i == 15), (i != 15));
      if (i == 2 || i == 9) begin
        add(1'b0, 5'd3, 5'd3, 8'h80, 1'b0, 8'd0, 1'b0, 1'b1);
        add(1'b0, 5'd3, 5'd3, 8'h7F, 1'b0, 8'd0, 1'b0, 1'b1);
      end
    end
    d2x2[0] = 8'h7F; d2x2[1] = 8'h80; d2x2[2] = 8'h80; d2x2[3] = 8'h80;
    for (int i = 0; i < 4; i++)
      add(1'b1, 5'd1, 5'd1, d2x2[i], (i == 3), 8'd127, (i == 3), (i != 3));
    add(1'b0, 5'd1, 5'd1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    b_hi = tbl.size() - 1;

    // Test 5: 4x4 ramp with geometry changed mid-frame, then 2x2 {-5,3,100,-128} back-to-back.
    c_lo = tbl.size();
    for (int i = 0; i < 16; i++)
      add(1'b1, (i == 0) ? 5'd3 : 5'd1, (i == 0) ? 5'd3 : 5'd1, 8'(i),
          (i == 5 || i == 7 || i == 13 || i == 15), 8'(i), (i == 15), (i != 15));
    d2x2[0] = 8'hFB; d2x2[1] = 8'd3; d2x2[2] = 8'd100; d2x2[3] = 8'h80;
    for (int i = 0; i < 4; i++)
      add(1'b1, 5'd1, 5'd1, d2x2[i], (i == 3), 8'd100, (i == 3), (i != 3));
    add(1'b0, 5'd1, 5'd1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    c_hi = tbl.size() - 1;
    d_lo = a_lo;
    d_hi = a_lo + 5;

    // Reset and check the idle output state.
    rst_n = 1'b0;
    bus.conv_valid_i  = 1'b0;
    bus.conv_result_i = 8'd0;
    bus.ofmap_w_i     = 5'd0;
    bus.ofmap_h_i     = 5'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset pool_valid", 32'(bus.pool_valid_o), 32'd0);
    chk("reset pool_result", 32'(bus.pool_result_o), 32'd0);
    chk("reset frame_done", 32'(bus.frame_done_o), 32'd0);
    chk("reset busy", 32'(bus.busy_o), 32'd0);

    apply_rows(a_lo, a_hi + 1, "ramp4x4");
    apply_rows(b_lo, b_hi, "neg_and_2x2");
    apply_rows(c_lo, c_hi, "back2back");

    // Test 6: abort after 6 pixels with an asynchronous reset, then a clean frame.
    apply_rows(d_lo, d_hi, "partial");
    #2 rst_n = 1'b0;
    #1;
    chk("async rst pool_valid", 32'(bus.pool_valid_o), 32'd0);
    chk("async rst pool_result", 32'(bus.pool_result_o), 32'd0);
    chk("async rst frame_done", 32'(bus.frame_done_o), 32'd0);
    chk("async rst busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = 8'd0;
    apply_rows(a_lo, a_hi + 1, "after_rst");

    // Test 4: 32x32 random signed pixels, valid deasserted about half the time.
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        pix[y][x] = 8'($urandom_range(0, 255));
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        expv[y][x] = max8(max8(relu8(pix[2*y][2*x]), relu8(pix[2*y][2*x+1])),
                          max8(relu8(pix[2*y+1][2*x]), relu8(pix[2*y+1][2*x+1])));
    idx = 0; cycles = 0; obs = 0;
    while (idx < 1024 && cycles < 6000) begin
      v = 1'($urandom_range(0, 1));
      r = idx / 32;
      c = idx % 32;
      step(v, 5'd31, 5'd31, v ? pix[r][c] : 8'($urandom_range(0, 255)));
      if (bus.pool_valid_o === 1'b1) obs++;
      if (v && r[0] && c[0]) begin
        chk($sformatf("rand px%0d pool_valid", idx), 32'(bus.pool_valid_o), 32'd1);
        chk($sformatf("rand px%0d pool_result", idx), 32'(bus.pool_result_o), 32'(expv[r/2][c/2]));
        chk($sformatf("rand px%0d frame_done", idx), 32'(bus.frame_done_o), 32'(idx == 1023));
      end else begin
        chk($sformatf("rand cyc%0d no pool_valid", cycles), 32'(bus.pool_valid_o), 32'd0);
      end
      if (v) idx++;
      cycles++;
    end
    chk("rand all pixels sent in budget", 32'(idx), 32'd1024);
    chk("rand output count", 32'(obs), 32'd256);
    step(1'b0, 5'd31, 5'd31, 8'd0);
    chk("rand busy after frame", 32'(bus.busy_o), 32'd0);
    chk("rand no trailing pool_valid", 32'(bus.pool_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
